pll_reconfig_sequencer: RTL

Management-side sequencer that retunes the fabric PLL at run time by driving the Avalon-MM management port of the PLL reconfiguration controller, whose reconfig_to_pll/reconfig_from_pll buses attach to the PLL instance. It accepts one frequency command, carrying the M feedback counter and the C0 output counter settings. It writes those settings, starts reconfiguration, polls for completion, then waits for a stable PLL lock. Adder test harnesses use it to sweep outclk_0 frequency without a bitstream reload.

---
 rtl/pll_reconfig_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer
//
// Retunes the fabric PLL at run time. It drives the Avalon-MM management port
// of the PLL reconfiguration controller and accepts one frequency command at a
// time. The sequence writes polling mode, then the M and C0 counter settings,
// then starts reconfiguration. It polls the status register until bit 0 is set
// and then waits for LOCK_STABLE consecutive cycles of synchronized lock.
//
// Ports
//   clk, rst            management clock, synchronous active-high reset
//   cmd_*               command handshake and M / C0 counter settings
//   busy, done, err     sequence status; done/err are one-cycle pulses
//   err_code            1 bad command, 2 bus/poll timeout, 3 lock timeout
//   mgmt_*              Avalon-MM master towards the reconfiguration controller
//   pll_locked          raw PLL lock, resynchronized internally
module pll_reconfig_sequencer #(
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int LOCK_STABLE  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_m_hi,
    input  logic [7:0]  cmd_m_lo,
    input  logic        cmd_m_odd,
    input  logic [7:0]  cmd_c0_hi,
    input  logic [7:0]  cmd_c0_lo,
    input  logic        cmd_c0_odd,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked
);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WR_MODE, ST_WR_M, ST_WR_C, ST_WR_START, ST_POLL_RD, ST_WAIT_LOCK
    } state_t;

    state_t        state_q, state_d;
    logic          gap_q, gap_d;          // idle cycle following a completed transfer
    logic          poll_ok_q, poll_ok_d;  // status bit 0 from the last completed read
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [17:0]   m_word_q, m_word_d;
    logic [17:0]   c_word_q, c_word_d;
    logic          lock_meta_q, lock_sync_q;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [5:0]    addr_q, addr_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [31:0]   wdata_q, wdata_d;

    logic xfer_done, timed_out, cmd_bad;
    logic unused_readdata;

    // Only the status bit of the controller read data is meaningful here.
    assign unused_readdata = ^mgmt_readdata[31:1];

    assign xfer_done = (read_q || write_q) && !mgmt_waitrequest;
    assign timed_out = (timer_q == TIMER_LAST);
    assign cmd_bad   = (cmd_m_hi == 8'd0) || (cmd_m_lo == 8'd0) ||
                       (cmd_c0_hi == 8'd0) || (cmd_c0_lo == 8'd0);

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        poll_ok_d  = poll_ok_q;
        timer_d    = timer_q + TW'(1);
        stable_d   = stable_q;
        m_word_d   = m_word_q;
        c_word_d   = c_word_q;
        cmd_ready_d = cmd_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        addr_d     = addr_q;
        read_d     = read_q;
        write_d    = write_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                timer_d     = '0;
                stable_d    = '0;
                gap_d       = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                // cmd_ready_q gates acceptance so the cycle after a done/err
                // pulse cannot accept; cmd_ready rises one cycle later.
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    m_word_d    = {cmd_m_odd, 1'b0, cmd_m_hi, cmd_m_lo};
                    c_word_d    = {cmd_c0_odd, 1'b0, cmd_c0_hi, cmd_c0_lo};
                    if (cmd_bad) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd1;
                    end else begin
                        state_d = ST_WR_MODE;
                        write_d = 1'b1;
                        addr_d  = 6'd0;
                        wdata_d = 32'd1;
                    end
                end
            end

            ST_WAIT_LOCK: begin
                stable_d = lock_sync_q ? stable_q + SW'(1) : '0;
                if (lock_sync_q && stable_q == STABLE_LAST) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    err_d      = 1'b1;
                    err_code_d = 2'd3;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                // Bus states: a strobe phase held until waitrequest drops,
                // then one idle gap cycle before the next transfer.
                if (!gap_q && xfer_done) begin
                    read_d    = 1'b0;
                    write_d   = 1'b0;
                    gap_d     = 1'b1;
                    poll_ok_d = mgmt_readdata[0];
                end else if (timed_out) begin
                    read_d     = 1'b0;
                    write_d    = 1'b0;
                    gap_d      = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    state_d    = ST_IDLE;
                end else if (gap_q) begin
                    gap_d   = 1'b0;
                    timer_d = '0;
                    case (state_q)
                        ST_WR_MODE: begin
                            state_d = ST_WR_M;
                            write_d = 1'b1;
                            addr_d  = 6'd4;
                            wdata_d = {14'b0, m_word_q};
                        end
                        ST_WR_M: begin
                            state_d = ST_WR_C;
                            write_d = 1'b1;
                            addr_d  = 6'd5;
                            wdata_d = {14'b0, c_word_q};
                        end
                        ST_WR_C: begin
                            state_d = ST_WR_START;
                            write_d = 1'b1;
                            addr_d  = 6'd2;
                            wdata_d = 32'd0;
                        end
                        ST_WR_START: begin
                            state_d = ST_POLL_RD;
                            read_d  = 1'b1;
                            addr_d  = 6'd1;
                            wdata_d = 32'd0;
                        end
                        default: begin
                            if (poll_ok_q) begin
                                state_d  = ST_WAIT_LOCK;
                                stable_d = '0;
                            end else begin
                                // Re-poll: the timeout spans all reads.
                                read_d  = 1'b1;
                                timer_d = timer_q + TW'(1);
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gap_q       <= 1'b0;
            poll_ok_q   <= 1'b0;
            timer_q     <= '0;
            stable_q    <= '0;
            m_word_q    <= '0;
            c_word_q    <= '0;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            addr_q      <= 6'd0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            poll_ok_q   <= poll_ok_d;
            timer_q     <= timer_d;
            stable_q    <= stable_d;
            m_word_q    <= m_word_d;
            c_word_q    <= c_word_d;
            lock_meta_q <= pll_locked;
            lock_sync_q <= lock_meta_q;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign err_code       = err_code_q;
    assign mgmt_address   = addr_q;
    assign mgmt_read      = read_q;
    assign mgmt_write     = write_q;
    assign mgmt_writedata = wdata_q;
endmodule
